// File: rtl/psum_drain.sv
// -----------------------------------------------------------------------------
// psum_drain
// Drains partial-sum entries from port B of the psum buffer and serialises each
// ARRAY_DIM-lane entry onto an AXI-Stream style output, lane 0 first. Each entry
// can optionally be zeroed in the buffer once it has been read.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start           one-cycle drain request (ignored unless idle)
//   i_num_entries     entries to drain, sampled with i_start (saturated to 2^ADDR_WIDTH)
//   i_clear_en        zero each entry after reading, sampled with i_start
//   o_busy, o_done    drain in progress / one-cycle completion pulse
//   o_b_addr          port B address (registered)
//   i_b_rdata         port B read data, one cycle after o_b_addr
//   o_b_wdata, o_b_wen port B write data (always zero) / write enable
//   o_m_tdata, o_m_tvalid, i_m_tready, o_m_tlast   output stream
// -----------------------------------------------------------------------------
module psum_drain #(
    parameter int ARRAY_DIM  = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic [ADDR_WIDTH:0]            i_num_entries,
    input  logic                           i_clear_en,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [ADDR_WIDTH-1:0]          o_b_addr,
    input  logic [ARRAY_DIM*ACC_WIDTH-1:0] i_b_rdata,
    output logic [ARRAY_DIM*ACC_WIDTH-1:0] o_b_wdata,
    output logic                           o_b_wen,
    output logic [ACC_WIDTH-1:0]           o_m_tdata,
    output logic                           o_m_tvalid,
    input  logic                           i_m_tready,
    output logic                           o_m_tlast
);

    localparam int LANE_W = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
    localparam int DATA_W = ARRAY_DIM * ACC_WIDTH;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [ADDR_WIDTH:0]  MAX_ENTRIES = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [LANE_W-1:0]    LAST_LANE   = LANE_W'(ARRAY_DIM - 1);

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_idx;    // current entry; doubles as the port B address
    logic [ADDR_WIDTH-1:0] r_last;   // index of the final entry (count - 1)
    logic [LANE_W-1:0]     r_lane;
    logic [DATA_W-1:0]     r_shift;
    logic                  r_clear;
    logic                  r_first;  // high only in the first SEND cycle of an entry

    logic [ADDR_WIDTH:0]   w_num_sat;
    logic                  w_lane_end;
    logic                  w_entry_end;
    logic                  w_send;

    // Saturating the count keeps r_last within the address range, so the
    // index can never wrap past the top of the buffer.
    assign w_num_sat   = (i_num_entries > MAX_ENTRIES) ? MAX_ENTRIES : i_num_entries;
    assign w_lane_end  = (r_lane == LAST_LANE);
    assign w_entry_end = (r_idx == r_last);
    assign w_send      = (r_state == S_SEND);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_last  <= '0;
            r_lane  <= '0;
            r_shift <= '0;
            r_clear <= 1'b0;
            r_first <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_idx   <= '0;
                        r_clear <= i_clear_en;
                        r_last  <= ADDR_WIDTH'(w_num_sat - 1'b1);
                        r_state <= (i_num_entries == '0) ? S_FIN : S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    // Read data for r_idx is valid now (one cycle after the address).
                    r_shift <= i_b_rdata;
                    r_lane  <= '0;
                    r_first <= 1'b1;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    r_first <= 1'b0;
                    if (i_m_tready) begin
                        r_shift <= r_shift >> ACC_WIDTH;
                        r_lane  <= r_lane + 1'b1;
                        if (w_lane_end) begin
                            if (w_entry_end) begin
                                r_state <= S_FIN;
                            end else begin
                                r_idx   <= r_idx + 1'b1;
                                r_state <= S_READ;
                            end
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // All outputs decode registered state only; nothing depends on i_m_tready.
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_FIN);
    assign o_b_addr   = r_idx;
    assign o_b_wdata  = '0;
    // The entry has already been captured in LATCH, so zeroing it in the
    // first SEND cycle cannot corrupt the words being streamed.
    assign o_b_wen    = w_send & r_first & r_clear;
    assign o_m_tvalid = w_send;
    assign o_m_tdata  = r_shift[ACC_WIDTH-1:0];
    assign o_m_tlast  = w_send & w_lane_end & w_entry_end;

endmodule

// File: tb/tb_psum_drain.sv
module tb_psum_drain;
    localparam int D    = 16;
    localparam int W    = 32;
    localparam int A    = 10;
    localparam int DW   = D * W;
    localparam int NMAX = 1 << A;

    logic          clk = 1'b0;
    logic          rst, start, clr, tready;
    logic [A:0]    num;
    logic          busy, done, wen, tvalid, tlast;
    logic [A-1:0]  addr;
    logic [DW-1:0] rdata, wdata;
    logic [W-1:0]  tdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    psum_drain #(.ARRAY_DIM(D), .ACC_WIDTH(W), .ADDR_WIDTH(A)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_entries(num),
        .i_clear_en(clr), .o_busy(busy), .o_done(done), .o_b_addr(addr),
        .i_b_rdata(rdata), .o_b_wdata(wdata), .o_b_wen(wen),
        .o_m_tdata(tdata), .o_m_tvalid(tvalid), .i_m_tready(tready),
        .o_m_tlast(tlast)
    );

    function automatic logic [W-1:0] word(input int e, input int l);
        return W'(e * 256 + l);
    endfunction

    function automatic logic [DW-1:0] pat(input int e);
        logic [DW-1:0] v;
        v = '0;
        for (int l = 0; l < D; l++) v[l*W +: W] = word(e, l);
        return v;
    endfunction

    // Psum buffer port B model: registered read, write of zero on wen.
    logic [DW-1:0] mem [0:NMAX-1];
    logic          fill_req = 1'b0;
    always @(posedge clk) begin
        if (fill_req) begin
            for (int e = 0; e < NMAX; e++) mem[e] <= pat(e);
        end else if (wen) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill();
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
    endtask

    // One drain from idle. n_req is what is driven, n_eff the expected entry
    // count. poke>0 pulses a second start (num=5) at that cycle.
    task automatic drain(input int n_req, input int n_eff, input bit c,
                         input bit rnd, input int poke);
        int tot, wi, wen_tot, dcyc, last_xfer, first_tv, busy_cnt, last_addr, budget;
        tot = n_eff * D; wi = 0; wen_tot = 0; dcyc = -1; last_xfer = -1;
        first_tv = -1; busy_cnt = 0; last_addr = -1;
        budget = n_eff * (D + 2) * (rnd ? 6 : 1) + 20;
        start = 1'b1; num = (A+1)'(n_req); clr = c; tready = 1'b1;
        for (int cyc = 1; cyc <= budget && dcyc < 0; cyc++) begin
            tick();
            if (cyc == 1) begin
                start = 1'b0; num = (A+1)'(5); clr = ~c;   // changes after sampling
            end
            if (cyc == poke) begin
                start = 1'b1; num = (A+1)'(5);
            end else if (cyc == poke + 1) begin
                start = 1'b0;
            end
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (busy) busy_cnt++;
            if (wen) begin
                wen_tot++;
                chk("wen_addr", 64'(addr), 64'(wi / D));
                chk("wen_first", 64'(tvalid && (wi % D == 0)), 64'd1);
                chk("wen_wdata", 64'(wdata != '0), 64'd0);
            end
            if (tvalid) begin
                if (first_tv < 0) first_tv = cyc;
                last_addr = int'(addr);
                chk("tdata", 64'(tdata), 64'(word(wi / D, wi % D)));
                chk("tlast", 64'(tlast), 64'(wi == tot - 1));
                if (tready) begin
                    wi++;
                    last_xfer = cyc;
                end
            end
            if (done) dcyc = cyc;
        end
        chk("done_seen", 64'(dcyc > 0), 64'd1);
        chk("word_count", 64'(wi), 64'(tot));
        chk("wen_count", 64'(wen_tot), 64'(c ? n_eff : 0));
        chk("busy_cycles", 64'(busy_cnt), 64'(dcyc));
        if (n_eff > 0) begin
            chk("first_tvalid_cyc", 64'(first_tv), 64'd3);
            chk("done_after_last", 64'(dcyc), 64'(last_xfer + 1));
            chk("last_addr", 64'(last_addr), 64'(n_eff - 1));
            if (!rnd) chk("done_latency", 64'(dcyc), 64'(n_eff * (D + 2) + 1));
        end else begin
            chk("no_tvalid", 64'(first_tv < 0), 64'd1);
            chk("done_latency0", 64'(dcyc), 64'd1);
        end
        tick();
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);
    endtask

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; num = '0; clr = 1'b0; tready = 1'b0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_wen", 64'(wen), 64'd0);
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_tdata", 64'(tdata), 64'd0);
        rst = 1'b0;
        fill();

        // Single entry, lanes 0..15, no clear.
        drain(1, 1, 1'b0, 1'b0, -1);

        // Three entries with clear: entries 0..2 zeroed, entry 3 untouched.
        drain(3, 3, 1'b1, 1'b0, -1);
        for (int e = 0; e < 3; e++) chk("cleared", 64'(mem[e] != '0), 64'd0);
        chk("not_cleared3", 64'(mem[3] == pat(3)), 64'd1);
        fill();

        // Two entries under random backpressure.
        drain(2, 2, 1'b0, 1'b1, -1);

        // Zero entries: straight to FIN, no stream, no writes.
        drain(0, 0, 1'b1, 1'b0, -1);

        // Second start mid-drain is ignored.
        drain(2, 2, 1'b0, 1'b0, 5);

        // Reset while word 7 of a single-entry drain is on the bus.
        num = (A+1)'(1); clr = 1'b1; start = 1'b1; tready = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("pre_rst_tdata", 64'(tdata), 64'(word(0, 7)));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_wen", 64'(wen), 64'd0);
        chk("mid_rst_tvalid", 64'(tvalid), 64'd0);
        chk("mid_rst_tlast", 64'(tlast), 64'd0);
        chk("mid_rst_addr", 64'(addr), 64'd0);
        chk("mid_rst_tdata", 64'(tdata), 64'd0);
        seen = 0;
        repeat (30) begin
            tick();
            if (done || wen || tvalid || busy) seen++;
        end
        chk("post_rst_quiet", 64'(seen), 64'd0);
        fill();

        // Full buffer, and an oversized count that saturates to the same.
        drain(1024, 1024, 1'b0, 1'b0, -1);
        drain(1100, 1024, 1'b0, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/psum_drain.md
PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 Parameter ARRAY_DIM, default 16, lanes per psum entry.
REQ-002 Parameter ACC_WIDTH, default 32, bits per lane and stream word width.
REQ-003 Parameter ADDR_WIDTH, default 10, psum buffer address width.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle drain request.
REQ-007 num_entries  in  ADDR_WIDTH+1  entries to drain (0..1024), sampled with start.
REQ-008 clear_en  in  1  zero each entry after reading, sampled with start.
REQ-009 busy  out  1  drain in progress.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 b_addr  out  ADDR_WIDTH  psum buffer port B address, registered.
REQ-012 b_rdata  in  ARRAY_DIM*ACC_WIDTH  port B read data, valid one cycle after b_addr.
REQ-013 b_wdata  out  ARRAY_DIM*ACC_WIDTH  port B write data, constant zero.
REQ-014 b_wen  out  1  port B write enable.
REQ-015 m_tdata  out  ACC_WIDTH  output stream data.
REQ-016 m_tvalid  out  1  stream valid.
REQ-017 m_tready  in  1  stream ready from sink.
REQ-018 m_tlast  out  1  marks the final word of the whole drain.

Function
REQ-019 FSM states SHALL be IDLE, READ, LATCH, SEND, FIN.
REQ-020 IDLE: start=1 with num_entries>0 SHALL latch num_entries and clear_en, set entry index 0, go to READ.
REQ-021 IDLE: start=1 with num_entries=0 SHALL go to FIN with no stream or BRAM activity.
REQ-022 READ (1 cycle): b_addr = entry index; next state LATCH.
REQ-023 LATCH (1 cycle): at its end, b_rdata is captured into a 512-bit shift register; lane counter set to 0; next state SEND.
REQ-024 SEND: m_tvalid=1; m_tdata = lane[lane_cnt] (lane 0 = bits [31:0] first, ascending).
REQ-025 A beat transfers only when m_tvalid and m_tready are both 1; m_tdata/m_tlast SHALL stay stable while m_tvalid=1 and m_tready=0.
REQ-026 m_tvalid SHALL NOT depend combinationally on m_tready.
REQ-027 On transfer of lane ARRAY_DIM-1: if entry index < num_entries-1, increment index and go to READ; else go to FIN.
REQ-028 m_tlast=1 only on lane ARRAY_DIM-1 of entry num_entries-1.
REQ-029 clear_en=1: b_wen=1 for exactly the first SEND cycle of each entry with b_addr held at that entry and b_wdata=0; clear_en=0: b_wen never asserted.
REQ-030 FIN (1 cycle): done=1, busy=0 next cycle; return to IDLE.
REQ-031 busy=1 in READ, LATCH, SEND, FIN; 0 in IDLE.
REQ-032 start while not IDLE SHALL be ignored; num_entries/clear_en changes after sampling have no effect.
REQ-033 Latency: first m_tvalid in the 3rd cycle after the start cycle; per entry overhead 2 cycles; full-rate drain of N entries takes N*(ARRAY_DIM+2)+1 cycles from start to done.
REQ-034 num_entries values > 2^ADDR_WIDTH SHALL be saturated to 2^ADDR_WIDTH; b_addr never wraps within a drain.

Reset
REQ-035 While rst=1: state IDLE; busy, done, b_wen, m_tvalid, m_tlast = 0; b_addr, m_tdata = 0; counters = 0.
REQ-036 rst asserted mid-drain SHALL abandon the drain without a done pulse; no b_wen after the reset cycle.

Verification
REQ-037 Entry 0 lanes = 0..15, num_entries=1, clear_en=0, m_tready=1 -> words 0..15 on consecutive cycles, tlast on word 15, done one cycle later, b_wen never high.
REQ-038 num_entries=3, clear_en=1, entries filled with 0x100*e+lane -> 48 words in order, b_wen pulses at addr 0,1,2 once each, buffer reads back all zero afterwards.
REQ-039 m_tready random ~50% during 2-entry drain -> no lost/duplicated word, data stable under stall, tlast only on word 31.
REQ-040 num_entries=0 -> done the cycle after FIN entry, no m_tvalid, no b_wen, busy high exactly one cycle.
REQ-041 start pulsed again mid-drain with num_entries=5 -> ignored, original count completes; rst at word 7 -> all outputs 0 next cycle, no done.
REQ-042 num_entries=1024, m_tready=1 -> 16384 words, last read address 1023, done at cycle 1024*18+1 after start.
